program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Fetch-stage program counter for the 5-stage RV32 pipeline.
- Holds the current fetch address (pc_current) and combinationally provides the sequential successor (pc_next = pc_current + 4).
- Each enabled cycle it loads either pc_next or a redirect target from the branch/jump resolution logic.
- Driven low by hazard control to stall fetch.

Parameters:
- XLEN, 32, address width in bits.
- RESET_ADDR, 32'h0000_0000, value loaded into pc_current on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  PC write enable; 0 = stall (hold PC).
- pc_src  input  1  next-PC select: 0 = sequential (pc_next), 1 = redirect (pc_target).
- pc_target  input  XLEN  branch/jump target address.
- pc_current  output  XLEN  registered current fetch address.
- pc_next  output  XLEN  combinational pc_current + 4.

Behaviour:
- Reset is synchronous, active-high, and sampled on the rising edge of clock. The interface decision is: reset rst, synchronous, active-high; clock clock.
- Priority on each rising edge: rst > enable > pc_src.
- rst=1: pc_current <= RESET_ADDR, regardless of enable, pc_src or pc_target.
- rst=0, enable=1, pc_src=0: pc_current <= pc_current + 4.
- rst=0, enable=1, pc_src=1: pc_current <= pc_target, loaded verbatim with no alignment masking.
  - Misaligned targets (e.g. 0x0000ABCD) are stored as-is.
- rst=0, enable=0: pc_current holds; pc_src and pc_target are ignored (a stalled redirect is dropped, not queued).
- pc_next is purely combinational: pc_current + 4, XLEN-bit modulo arithmetic.
  - Wrap-around example: 0xFFFFFFFC -> 0x00000000, with no carry/overflow output.
- Both outputs settle within the same cycle; there is no extra latency.
- A redirect takes effect one cycle after it is presented with enable=1.
- After reset: pc_current = RESET_ADDR and pc_next = RESET_ADDR + 4.
- Reset asserted mid-stream overrides a simultaneous redirect or increment. On the first enabled cycle after release, the PC increments from RESET_ADDR.
- Back-to-back redirects are each honoured on consecutive cycles.
- No X-propagation from pc_target when pc_src=0 or enable=0.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - Adds output target_misaligned (1 bit, combinational).
  - target_misaligned = enable & pc_src & ~rst & (pc_target[1:0] != 2'b00).
  - The PC still loads pc_target verbatim; this is a flag for the exception unit only.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (e.g. riscv_pkg) holds:
  - XLEN = 32
  - INSTR_BYTES = 4 (the increment constant)
  - the default RESET_ADDR constant
  - typedef addr_t = logic [XLEN-1:0]
- No sub-module is natural: one register plus one adder and a 2:1 mux, implemented inline.

Test Plan:
1. Reset: rst=1, enable=1, pc_src=0 for one edge -> pc_current=0x00000000, pc_next=0x00000004.
2. Sequential: rst=0, enable=1, pc_src=0 over 5 edges -> pc_current 0x4, 0x8, 0xC, 0x10, 0x14, with pc_next = pc_current+4 each cycle.
3. Redirect and consecutive redirects: targets 0x1000, 0x2000, 0x3000 on consecutive edges, then sequential -> pc_current follows 0x1000, 0x2000, 0x3000, 0x3004.
4. Stall: jump to 0x100, then 3 edges with enable=0, including one with pc_src=1, pc_target=0x5000 -> pc_current stays 0x100. Next enabled sequential edge -> 0x104.
5. Mid-operation reset: jump to 0xABCD (stored unaligned), increment to 0xABD1, then rst=1 -> 0x0. Release, next edge -> 0x4.
6. Wrap-around: jump to 0xFFFFFFF8, then increment -> 0xFFFFFFFC (pc_next=0x00000000), then increment -> 0x00000000 (pc_next=0x00000004). With PC_MISALIGN_CHK_EN defined, target 0xABCD raises target_misaligned and 0x1000 does not.

Source files
------------

// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared constants and types for the fetch-stage program counter
//
// Purpose: address width, instruction increment, default reset vector and the
// address type used by the fetch stage.
package program_counter_pkg;

  localparam int XLEN = 32;

  // Every RV32 instruction fetched here is 4 bytes; pc_next steps by this.
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-stage program counter with stall and redirect
//
// Purpose: holds the current fetch address and selects the next one each
// enabled cycle, either the sequential successor or a redirect target.
//
// Ports:
//   clock             in   rising-edge clock
//   rst               in   synchronous, active-high reset (loads RESET_ADDR)
//   enable            in   PC write enable; 0 stalls fetch and drops any redirect
//   pc_src            in   0 = sequential (pc_next), 1 = redirect (pc_target)
//   pc_target         in   [XLEN-1:0] redirect address, loaded verbatim
//   pc_current        out  [XLEN-1:0] registered fetch address
//   pc_next           out  [XLEN-1:0] combinational pc_current + 4 (modulo 2^XLEN)
//   target_misaligned out  only with PC_MISALIGN_CHK_EN: redirect target not
//                          word aligned (flag for the exception unit)
//
// Build option: PC_MISALIGN_CHK_EN adds the target_misaligned output.
module program_counter #(
  parameter int               XLEN       = program_counter_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_ADDR = program_counter_pkg::RESET_ADDR
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            enable,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
`ifdef PC_MISALIGN_CHK_EN
  output logic            target_misaligned,
`endif
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_next
);

  import program_counter_pkg::*;

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Wraps silently at the top of the address space; no carry is reported.
  assign pc_next    = pc_q + XLEN'(INSTR_BYTES);
  assign pc_current = pc_q;

  // Branching on pc_src (rather than masking) keeps an undriven pc_target
  // from leaking into the PC on sequential or stalled cycles.
  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = RESET_ADDR;
    end else if (enable) begin
      if (pc_src) begin
        pc_d = pc_target;
      end else begin
        pc_d = pc_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    pc_q <= pc_d;
  end

`ifdef PC_MISALIGN_CHK_EN
  // Only meaningful for a redirect that will actually be taken this edge.
  assign target_misaligned = enable & pc_src & ~rst & (pc_target[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter
module tb_program_counter;

  logic        clock;
  logic        rst;
  logic        enable;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
`ifdef PC_MISALIGN_CHK_EN
  logic        target_misaligned;
`endif

  int total;
  int bad;

  program_counter dut (
    .clock             (clock),
    .rst               (rst),
    .enable            (enable),
    .pc_src            (pc_src),
    .pc_target         (pc_target),
`ifdef PC_MISALIGN_CHK_EN
    .target_misaligned (target_misaligned),
`endif
    .pc_current        (pc_current),
    .pc_next           (pc_next)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic en, input logic src, input logic [31:0] tgt);
    rst       = r;
    enable    = en;
    pc_src    = src;
    pc_target = tgt;
    @(posedge clock);
    #1;
  endtask

  // Check both outputs against a hand-computed PC.
  task automatic chk_pc(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_cur"}, pc_current, exp_pc);
    chk({tag, "_nxt"}, pc_next, exp_pc + 32'd4);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    enable    = 1'b1;
    pc_src    = 1'b0;
    pc_target = 32'h0;

    // 1. reset
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk_pc("reset", 32'h0000_0000);

    // 2. sequential
    step(1'b0, 1'b1, 1'b0, 32'h0);  chk_pc("seq1", 32'h0000_0004);
    step(1'b0, 1'b1, 1'b0, 32'h0);  chk_pc("seq2", 32'h0000_0008);
    step(1'b0, 1'b1, 1'b0, 32'h0);  chk_pc("seq3", 32'h0000_000C);
    step(1'b0, 1'b1, 1'b0, 32'h0);  chk_pc("seq4", 32'h0000_0010);
    step(1'b0, 1'b1, 1'b0, 32'h0);  chk_pc("seq5", 32'h0000_0014);

    // 3. back-to-back redirects then sequential
    step(1'b0, 1'b1, 1'b1, 32'h0000_1000);  chk_pc("redir1", 32'h0000_1000);
    step(1'b0, 1'b1, 1'b1, 32'h0000_2000);  chk_pc("redir2", 32'h0000_2000);
    step(1'b0, 1'b1, 1'b1, 32'h0000_3000);  chk_pc("redir3", 32'h0000_3000);
    step(1'b0, 1'b1, 1'b0, 32'h0000_7777);  chk_pc("redir_seq", 32'h0000_3004);

    // 4. stall, including a dropped redirect
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);  chk_pc("jmp100", 32'h0000_0100);
    step(1'b0, 1'b0, 1'b0, 32'h0);          chk_pc("stall1", 32'h0000_0100);
    step(1'b0, 1'b0, 1'b1, 32'h0000_5000);  chk_pc("stall2", 32'h0000_0100);
    step(1'b0, 1'b0, 1'b0, 32'h0);          chk_pc("stall3", 32'h0000_0100);
    step(1'b0, 1'b1, 1'b0, 32'h0);          chk_pc("unstall", 32'h0000_0104);

    // undriven target must not reach the PC when not selected
    step(1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx);  chk_pc("xtgt_seq", 32'h0000_0108);
    step(1'b0, 1'b0, 1'b1, 32'hxxxx_xxxx);  chk_pc("xtgt_stall", 32'h0000_0108);

    // 5. unaligned jump, then reset overriding a redirect
    step(1'b0, 1'b1, 1'b1, 32'h0000_ABCD);  chk_pc("unalign", 32'h0000_ABCD);
    step(1'b0, 1'b1, 1'b0, 32'h0);          chk_pc("unalign_seq", 32'h0000_ABD1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_9999);  chk_pc("midrst", 32'h0000_0000);
    step(1'b0, 1'b1, 1'b0, 32'h0);          chk_pc("rst_release", 32'h0000_0004);

    // 6. wrap-around
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);  chk_pc("wrap_jmp", 32'hFFFF_FFF8);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap1_cur", pc_current, 32'hFFFF_FFFC);
    chk("wrap1_nxt", pc_next,    32'h0000_0000);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap2_cur", pc_current, 32'h0000_0000);
    chk("wrap2_nxt", pc_next,    32'h0000_0004);

`ifdef PC_MISALIGN_CHK_EN
    rst = 1'b0; enable = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_ABCD;
    #1 chk("mis_abcd", {31'd0, target_misaligned}, 32'd1);
    pc_target = 32'h0000_1000;
    #1 chk("mis_1000", {31'd0, target_misaligned}, 32'd0);
    pc_target = 32'h0000_0002; enable = 1'b0;
    #1 chk("mis_stall", {31'd0, target_misaligned}, 32'd0);
    enable = 1'b1; rst = 1'b1;
    #1 chk("mis_rst", {31'd0, target_misaligned}, 32'd0);
    rst = 1'b0; pc_src = 1'b0;
    #1 chk("mis_seq", {31'd0, target_misaligned}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
